main_memory_arbiter: RTL
========================

Name: main_memory_arbiter

Overview:
- Shares the single main_memory port between two requesters.
  - Port 0: CPU core (instruction fetch, load, store).
  - Port 1: program loader / debug DMA.
- Sits between the requesters and main_memory. It replaces direct wiring of main_memory_control to the memory.
- Req/grant handshake with a registered grant.
- Round-robin tie-break, plus a burst limit so that neither side can starve the other.

Parameters:
- ADDR_WIDTH, 32, address width of both ports and of the memory.
- DATA_WIDTH, 32, data width of both ports and of the memory.
- MAX_BURST, 8, maximum consecutive owned cycles under contention before a forced handoff; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held high until the access completes.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_WIDTH  port 0 address.
- wdata0  in  DATA_WIDTH  port 0 write data.
- gnt0  out  1  port 0 owns the memory this cycle.
- rdata0  out  DATA_WIDTH  port 0 read data; valid when gnt0 is high.
- req1, we1, addr1, wdata1, gnt1, rdata1  same as port 0, for port 1.
- mem_read_address  out  ADDR_WIDTH  to main_memory.
- mem_write_address  out  ADDR_WIDTH  to main_memory.
- mem_write_data  out  DATA_WIDTH  to main_memory.
- mem_write_enable  out  1  to main_memory.
- mem_read_data  in  DATA_WIDTH  from main_memory; combinational read.

Behaviour:
- State machine states: IDLE, OWN0, OWN1. gnt0 = (state==OWN0); gnt1 = (state==OWN1). Both grants are registered, so there is 1 cycle of latency from req rising to gnt rising.
- Reset (asynchronous, active-high):
  - state = IDLE; gnt0 = gnt1 = 0; burst_cnt = 0; last_owner = 1, so port 0 wins the first tie.
  - All mem_* outputs are 0. rdata0 = rdata1 = 0.
- Reset mid-operation: the grant drops immediately and asynchronously, so mem_write_enable falls before the next edge and no write occurs.
- Transitions from IDLE:
  - Only req0 → OWN0. Only req1 → OWN1.
  - Both requesting → grant the port that is not last_owner.
  - Neither requesting → stay in IDLE.
- Transitions from OWNx:
  - req_x low → OWN_other if req_other is high, else IDLE. Handoff is direct, with no dead cycle.
  - req_x high, req_other high and burst_cnt == MAX_BURST-1 → OWN_other (forced handoff).
  - Otherwise stay in OWNx.
  - The losing requester keeps req high and simply waits; the dropped access repeats once it is re-granted.
- burst_cnt:
  - Width is max(1, $clog2(MAX_BURST)).
  - Cleared on every entry into OWN0 or OWN1.
  - Increments each cycle the owner stays; saturates at MAX_BURST-1.
  - With MAX_BURST=1, contention alternates the owner every cycle.
- last_owner is updated whenever a grant is issued.
- Memory steering, combinational from the current owner when gnt_x is high:
  - mem_read_address = addr_x; mem_write_address = addr_x; mem_write_data = wdata_x.
  - mem_write_enable = gnt_x & req_x & we_x.
  - With no owner, all mem_* outputs are 0.
- Read data: rdata_x = mem_read_data while gnt_x is high, else 0. Read data is valid in the same cycle as the grant.
- Write timing: a write commits at the clk edge that ends a cycle in which mem_write_enable is high. One access is performed per granted cycle.
- The non-owner's we, addr and wdata never reach the memory.

Decomposition:
- Shared arch_defines.v gains the state encodings ARB_IDLE, ARB_OWN0, ARB_OWN1 as 2-bit defines.
- State, burst_cnt and last_owner are held in reg_async_reset instances.
- One combinational sub-module is natural: mem_port_mux. It selects owner inputs onto the mem_* outputs and routes mem_read_data to rdata0/rdata1. The FSM stays in the top module.

Test Plan:
- Reset / idle:
  - Stimulus: assert rst mid-cycle while OWN0 with we0=1, then release; no requests.
  - Required: gnt0 falls immediately; mem_write_enable=0; the targeted word is unchanged.
  - After release: state IDLE, gnt0=gnt1=0, all mem_* = 0.
- Single requester write then read:
  - Stimulus: req0=1, we0=1, addr0=0x10, wdata0=0xDEADBEEF.
  - Required: gnt0 rises one cycle later; memory[0x10] is written at the following edge.
  - Then set we0=0: rdata0 = 0xDEADBEEF in the same granted cycle.
- Simultaneous request after reset:
  - Stimulus: req0 and req1 rise together.
  - Required: OWN0 first. Drop req0 after 2 cycles → gnt1 in the next cycle, with no IDLE cycle in between.
- Starvation guard (MAX_BURST=8):
  - Stimulus: req0 and req1 held high continuously.
  - Required: grants alternate in runs of 8 cycles: 8 cycles gnt0, then 8 cycles gnt1, repeating.
- Isolation:
  - Stimulus: while OWN1 with we1=0, drive we0=1, addr0=0x20, wdata0=0x1234.
  - Required: memory[0x20] is unchanged; rdata0 = 0; mem_read_address = addr1.
- MAX_BURST=1 variant:
  - Stimulus: continuous dual requests.
  - Required: gnt0 and gnt1 toggle every cycle; burst_cnt stays 0.

Source files
------------

// File: rtl/main_memory_arbiter_pkg.sv
// Shared types and helpers for the main memory arbiter: FSM state encoding
// and burst counter sizing.
package main_memory_arbiter_pkg;

    localparam int ARB_STATE_W = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    // A single-cycle burst limit still needs a one-bit counter.
    function automatic int burst_cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/main_memory_arbiter_if.sv
// Bundle of the two requester ports and the main_memory port seen by the arbiter.
interface main_memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic [DATA_WIDTH-1:0] rdata0;

    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic [ADDR_WIDTH-1:0] mem_read_address;
    logic [ADDR_WIDTH-1:0] mem_write_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_write_enable;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_read_data,
        output gnt0, rdata0, gnt1, rdata1,
        output mem_read_address, mem_write_address, mem_write_data, mem_write_enable
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_read_data,
        input  gnt0, rdata0, gnt1, rdata1,
        input  mem_read_address, mem_write_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/main_memory_arbiter_mem_port_mux.sv
// Steers the current owner's request onto main_memory and returns read data to
// that owner only; with no owner every memory-side output is zero.
module main_memory_arbiter_mem_port_mux #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  gnt0,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  gnt1,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_enable,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1
);

    // Owner selection onto the memory port; grants are one-hot by construction
    always_comb begin
        mem_read_address  = '0;
        mem_write_address = '0;
        mem_write_data    = '0;
        mem_write_enable  = 1'b0;
        if (gnt0) begin
            mem_read_address  = addr0;
            mem_write_address = addr0;
            mem_write_data    = wdata0;
            mem_write_enable  = req0 & we0;
        end else if (gnt1) begin
            mem_read_address  = addr1;
            mem_write_address = addr1;
            mem_write_data    = wdata1;
            mem_write_enable  = req1 & we1;
        end else begin
            mem_write_enable  = 1'b0;
        end
    end

    // Read data return, gated so the non-owner always sees zero
    always_comb begin
        rdata0 = '0;
        rdata1 = '0;
        if (gnt0) begin
            rdata0 = mem_read_data;
        end else if (gnt1) begin
            rdata1 = mem_read_data;
        end else begin
            rdata0 = '0;
        end
    end

endmodule

// File: rtl/reg_async_reset.sv
// Plain D register with asynchronous active-high reset to a parameterised value.
module reg_async_reset #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage element
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/main_memory_arbiter.sv
// Two-port arbiter for main_memory: registered grants, round-robin tie-break and a
// burst limit that forces a handoff when the other side has been waiting.
module main_memory_arbiter
    import main_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    main_memory_arbiter_if.slave bus
);

    localparam int            BW         = burst_cnt_width(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    logic [ARB_STATE_W-1:0] state_q_s;
    arb_state_e             state_r;
    arb_state_e             state_nxt_s;
    logic [BW-1:0]          burst_cnt_r;
    logic [BW-1:0]          burst_cnt_nxt_s;
    logic                   last_owner_r;
    logic                   last_owner_nxt_s;
    logic                   burst_done_s;
    logic                   gnt0_s;
    logic                   gnt1_s;

    reg_async_reset #(.WIDTH(ARB_STATE_W), .RESET_VALUE(ARB_IDLE)) u_state_reg (
        .clk(clk), .rst(rst), .d(state_nxt_s), .q(state_q_s)
    );

    reg_async_reset #(.WIDTH(BW), .RESET_VALUE('0)) u_burst_reg (
        .clk(clk), .rst(rst), .d(burst_cnt_nxt_s), .q(burst_cnt_r)
    );

    // Reset value 1 lets port 0 win the first tie
    reg_async_reset #(.WIDTH(1), .RESET_VALUE(1'b1)) u_last_owner_reg (
        .clk(clk), .rst(rst), .d(last_owner_nxt_s), .q(last_owner_r)
    );

    assign state_r      = arb_state_e'(state_q_s);
    assign burst_done_s = (burst_cnt_r == BURST_LAST);

    // Next-state selection
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_nxt_s = last_owner_r ? ARB_OWN0 : ARB_OWN1;
                end else if (bus.req0) begin
                    state_nxt_s = ARB_OWN0;
                end else if (bus.req1) begin
                    state_nxt_s = ARB_OWN1;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_OWN0: begin
                if (!bus.req0) begin
                    state_nxt_s = bus.req1 ? ARB_OWN1 : ARB_IDLE;
                end else if (bus.req1 && burst_done_s) begin
                    state_nxt_s = ARB_OWN1;
                end else begin
                    state_nxt_s = ARB_OWN0;
                end
            end
            ARB_OWN1: begin
                if (!bus.req1) begin
                    state_nxt_s = bus.req0 ? ARB_OWN0 : ARB_IDLE;
                end else if (bus.req0 && burst_done_s) begin
                    state_nxt_s = ARB_OWN0;
                end else begin
                    state_nxt_s = ARB_OWN1;
                end
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // Burst length and round-robin history follow every grant change
    always_comb begin
        burst_cnt_nxt_s  = burst_cnt_r;
        last_owner_nxt_s = last_owner_r;
        if (state_nxt_s == ARB_IDLE) begin
            burst_cnt_nxt_s = '0;
        end else if (state_nxt_s != state_r) begin
            burst_cnt_nxt_s  = '0;
            last_owner_nxt_s = (state_nxt_s == ARB_OWN1);
        end else if (!burst_done_s) begin
            burst_cnt_nxt_s = burst_cnt_r + BW'(1);
        end else begin
            burst_cnt_nxt_s = burst_cnt_r;
        end
    end

    // Grant decode from the registered state
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        case (state_r)
            ARB_OWN0: gnt0_s = 1'b1;
            ARB_OWN1: gnt1_s = 1'b1;
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
    end

    assign bus.gnt0 = gnt0_s;
    assign bus.gnt1 = gnt1_s;

    main_memory_arbiter_mem_port_mux #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem_port_mux (
        .gnt0             (gnt0_s),
        .req0             (bus.req0),
        .we0              (bus.we0),
        .addr0            (bus.addr0),
        .wdata0           (bus.wdata0),
        .gnt1             (gnt1_s),
        .req1             (bus.req1),
        .we1              (bus.we1),
        .addr1            (bus.addr1),
        .wdata1           (bus.wdata1),
        .mem_read_data    (bus.mem_read_data),
        .mem_read_address (bus.mem_read_address),
        .mem_write_address(bus.mem_write_address),
        .mem_write_data   (bus.mem_write_data),
        .mem_write_enable (bus.mem_write_enable),
        .rdata0           (bus.rdata0),
        .rdata1           (bus.rdata1)
    );

endmodule
